bilinear_feeder: RTL and testbench
==================================

BILINEAR_FEEDER -- requirements
Module: bilinear_feeder

Interface
REQ-001 Parameters: DIM_W, default 12, image dimension width; ADDR_W, default 24, source-memory address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_cfg_start  input  1  one-cycle pulse; begins a frame; ignored unless IDLE.
REQ-005 i_src_w, i_src_h  input  DIM_W each  source dimensions in pixels.
REQ-006 i_dst_w, i_dst_h  input  DIM_W each  destination dimensions in pixels.
REQ-007 i_step_x, i_step_y  input  16 each  source step per destination pixel, unsigned Q8.8.
REQ-008 o_rd_en  output  1  source-memory read strobe.
REQ-009 o_rd_addr  output  ADDR_W  source address, row-major, y*src_w + x.
REQ-010 i_rd_data  input  8  read data, valid exactly 1 cycle after o_rd_en.
REQ-011 o_start  output  1  one-cycle pulse; neighbourhood valid for the interpolator.
REQ-012 o_p1, o_p2, o_p3, o_p4  output  8 each  pixels (x0,y0), (x1,y0), (x0,y1), (x1,y1).
REQ-013 o_wx, o_wy  output  16 each  Q8.8 fractional weights.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_done  output  1  one-cycle pulse after the last o_start of a frame.

Function
REQ-016 Config inputs SHALL be latched on an accepted i_cfg_start; later changes SHALL NOT affect the frame in progress.
REQ-017 FSM states: IDLE, R1, R2, R3, R4, CAP, EMIT, FIN.
REQ-018 IDLE -> R1 on i_cfg_start when i_dst_w and i_dst_h are both nonzero; IDLE -> FIN when either is zero.
REQ-019 R1..R4: one state per cycle, o_rd_en=1, with o_rd_addr for p1, p2, p3, p4 in that order.
REQ-020 Data read in state Rn SHALL be captured into o_p(n) on the following cycle; p4 SHALL be captured in CAP.
REQ-021 EMIT: o_start=1 for one cycle; o_p1..o_p4, o_wx, o_wy SHALL be stable and SHALL hold until the next EMIT.
REQ-022 After EMIT: if not the last pixel of the frame -> R1, else -> FIN; FIN -> IDLE with o_done=1 for one cycle.
REQ-023 Throughput: exactly 6 cycles per destination pixel. The first o_rd_en SHALL occur 1 cycle after i_cfg_start. The first o_start SHALL occur 6 cycles after i_cfg_start.
REQ-024 Scan order: raster, dst_x fastest.
REQ-025 Source position accumulators: 20-bit unsigned Q12.8, both reset to 0 at frame start.
REQ-026 acc_x += step_x after each pixel; at end of each row, acc_x=0 and acc_y += step_y.
REQ-027 x0 = min(acc_x[19:8], src_w-1); x1 = min(x0+1, src_w-1); y0 and y1 are derived from acc_y the same way.
REQ-028 o_wx = {8'h00, acc_x[7:0]}; o_wy = {8'h00, acc_y[7:0]}.
REQ-029 When x0 or y0 is clamped, the corresponding weight SHALL be forced to 0.
REQ-030 Accumulator overflow past 20 bits SHALL saturate at 20'hFFFFF; there is no wrap-around.
REQ-031 Address arithmetic SHALL be unsigned and full-width; a product exceeding ADDR_W SHALL be truncated. Integration sizes src_w*src_h <= 2^ADDR_W.
REQ-032 i_cfg_start while o_busy=1 SHALL be ignored, with no restart and no state corruption.

Reset
REQ-033 While rst_n=0 at a clock edge: state=IDLE; accumulators, counters, o_p1..o_p4, o_wx, o_wy, o_rd_addr = 0; o_rd_en, o_start, o_busy, o_done = 0.
REQ-034 Reset mid-frame SHALL abort the frame with no further o_start or o_done; a new i_cfg_start SHALL be accepted on the first cycle after rst_n returns high.

Verification
REQ-035 src 2x2 = {10,20,30,40}, dst 2x2, step 0x0100/0x0100 -> 4 o_start pulses, 6 cycles apart:
- pixel 0: addr order 0,1,2,3; p=10,20,30,40; wx=wy=0.
- pixel 1: x0=1, clamped, addrs 1,1,3,3.
- o_done asserts 1 cycle after the 4th o_start.
REQ-036 src 2x1 = {0,200}, dst 3x1, step_x 0x0080 -> wx = 0x0000, 0x0080, 0x0000; for the third pixel x0=1, clamped, and p1=p2=200.
REQ-037 i_dst_w=0 -> o_done pulses 2 cycles after i_cfg_start; no o_rd_en and no o_start.
REQ-038 i_cfg_start re-pulsed during a frame, with different config -> output sequence identical to a run without the re-pulse.
REQ-039 rst_n=0 for 1 cycle after the 2nd o_start -> all outputs 0 next cycle, no o_done; a new frame started afterwards produces the correct first pixel.
REQ-040 step_x=0xFFFF, dst_w=4095 -> acc_x saturates, x0 stays at src_w-1, no address beyond src_w*src_h-1.

Source files
------------

// File: rtl/bilinear_feeder.sv
// Bilinear neighbourhood fetcher: walks the destination raster, reads the 2x2 source
// neighbourhood for each pixel and presents it with its Q8.8 weights to an interpolator.
module bilinear_feeder #(
    parameter int unsigned DIM_W  = 12,
    parameter int unsigned ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cfg_start,
    input  logic [DIM_W-1:0]  i_src_w,
    input  logic [DIM_W-1:0]  i_src_h,
    input  logic [DIM_W-1:0]  i_dst_w,
    input  logic [DIM_W-1:0]  i_dst_h,
    input  logic [15:0]       i_step_x,
    input  logic [15:0]       i_step_y,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic              o_start,
    output logic [7:0]        o_p1,
    output logic [7:0]        o_p2,
    output logic [7:0]        o_p3,
    output logic [7:0]        o_p4,
    output logic [15:0]       o_wx,
    output logic [15:0]       o_wy,
    output logic              o_busy,
    output logic              o_done
);

    // wide enough for the 12-bit integer part of an accumulator and any dimension
    localparam int unsigned CW = DIM_W + 13;
    localparam int unsigned FW = ADDR_W + 2 * CW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R1,
        S_R2,
        S_R3,
        S_R4,
        S_CAP,
        S_EMIT,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [DIM_W-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q;
    logic [DIM_W-1:0] dx_q, dy_q;
    logic [15:0]      step_x_q, step_y_q;
    logic [19:0]      acc_x_q, acc_y_q;
    logic             fin_hold_q;
    logic [7:0]       s1_q, s2_q, s3_q;
    logic [7:0]       p1_q, p2_q, p3_q, p4_q;
    logic [15:0]      wx_q, wy_q;

    logic [CW-1:0]    ix, iy, xmax, ymax;
    logic [CW-1:0]    x0, x1, y0, y1, xsel, ysel;
    logic             x_edge, y_edge;
    logic [20:0]      sum_x, sum_y;
    logic [19:0]      acc_x_inc, acc_y_inc;
    logic             row_end, last_pix, empty_cfg;
    logic [ADDR_W-1:0] addr;

    // Neighbourhood coordinates, clamped to the source image
    always_comb begin
        ix     = CW'(acc_x_q[19:8]);
        iy     = CW'(acc_y_q[19:8]);
        xmax   = (src_w_q == '0) ? '0 : CW'(src_w_q) - CW'(1);
        ymax   = (src_h_q == '0) ? '0 : CW'(src_h_q) - CW'(1);
        x_edge = (ix >= xmax);
        y_edge = (iy >= ymax);
        x0     = x_edge ? xmax : ix;
        x1     = x_edge ? xmax : ix + CW'(1);
        y0     = y_edge ? ymax : iy;
        y1     = y_edge ? ymax : iy + CW'(1);
    end

    always_comb begin
        xsel = x0;
        ysel = y0;
        case (state_q)
            S_R2: xsel = x1;
            S_R3: ysel = y1;
            S_R4: begin
                xsel = x1;
                ysel = y1;
            end
            default: ;
        endcase
        addr = ADDR_W'(FW'(ysel) * FW'(src_w_q) + FW'(xsel));
    end

    always_comb begin
        sum_x     = {1'b0, acc_x_q} + 21'(step_x_q);
        sum_y     = {1'b0, acc_y_q} + 21'(step_y_q);
        acc_x_inc = sum_x[20] ? 20'hFFFFF : sum_x[19:0];
        acc_y_inc = sum_y[20] ? 20'hFFFFF : sum_y[19:0];
        row_end   = (dx_q == dst_w_q - DIM_W'(1));
        last_pix  = row_end && (dy_q == dst_h_q - DIM_W'(1));
        empty_cfg = (i_dst_w == '0) || (i_dst_h == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_rd_en = 1'b0;
        o_start = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_cfg_start) begin
                    state_d = empty_cfg ? S_FIN : S_R1;
                end
            end
            S_R1: begin
                o_rd_en = 1'b1;
                state_d = S_R2;
            end
            S_R2: begin
                o_rd_en = 1'b1;
                state_d = S_R3;
            end
            S_R3: begin
                o_rd_en = 1'b1;
                state_d = S_R4;
            end
            S_R4: begin
                o_rd_en = 1'b1;
                state_d = S_CAP;
            end
            S_CAP: state_d = S_EMIT;
            S_EMIT: begin
                o_start = 1'b1;
                state_d = last_pix ? S_FIN : S_R1;
            end
            // an empty frame lingers one extra cycle here so its o_done lands two
            // cycles after the start, like a pixel frame's lands one after EMIT
            S_FIN: begin
                if (!fin_hold_q) begin
                    o_done  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fetched pixels go through a staging set so the outputs hold from one EMIT to the next
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_w_q    <= '0;
            src_h_q    <= '0;
            dst_w_q    <= '0;
            dst_h_q    <= '0;
            step_x_q   <= '0;
            step_y_q   <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            fin_hold_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            p3_q       <= '0;
            p4_q       <= '0;
            wx_q       <= '0;
            wy_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_cfg_start) begin
                        src_w_q    <= i_src_w;
                        src_h_q    <= i_src_h;
                        dst_w_q    <= i_dst_w;
                        dst_h_q    <= i_dst_h;
                        step_x_q   <= i_step_x;
                        step_y_q   <= i_step_y;
                        dx_q       <= '0;
                        dy_q       <= '0;
                        acc_x_q    <= '0;
                        acc_y_q    <= '0;
                        fin_hold_q <= empty_cfg;
                    end
                end
                S_R2: s1_q <= i_rd_data;
                S_R3: s2_q <= i_rd_data;
                S_R4: s3_q <= i_rd_data;
                S_CAP: begin
                    p1_q <= s1_q;
                    p2_q <= s2_q;
                    p3_q <= s3_q;
                    p4_q <= i_rd_data;
                    wx_q <= x_edge ? '0 : {8'h00, acc_x_q[7:0]};
                    wy_q <= y_edge ? '0 : {8'h00, acc_y_q[7:0]};
                end
                S_EMIT: begin
                    if (row_end) begin
                        dx_q    <= '0;
                        acc_x_q <= '0;
                        dy_q    <= dy_q + DIM_W'(1);
                        acc_y_q <= acc_y_inc;
                    end else begin
                        dx_q    <= dx_q + DIM_W'(1);
                        acc_x_q <= acc_x_inc;
                    end
                end
                S_FIN: fin_hold_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_rd_addr = o_rd_en ? addr : '0;
    assign o_busy    = (state_q != S_IDLE);
    assign o_p1      = p1_q;
    assign o_p2      = p2_q;
    assign o_p3      = p3_q;
    assign o_p4      = p4_q;
    assign o_wx      = wx_q;
    assign o_wy      = wy_q;

endmodule

// File: tb/tb_bilinear_feeder.sv
// Directed bench for bilinear_feeder: table of expected neighbourhoods per frame plus
// hand-written sequences for empty frames, re-pulsed start, mid-frame reset and saturation.
module tb_bilinear_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [11:0] src_w, src_h, dst_w, dst_h;
    logic [15:0] step_x, step_y;
    logic        rd_en;
    logic [23:0] rd_addr;
    logic [7:0]  rd_data;
    logic        start;
    logic [7:0]  p1, p2, p3, p4;
    logic [15:0] wx, wy;
    logic        busy, done;

    always #5 clk = ~clk;

    bilinear_feeder #(.DIM_W(12), .ADDR_W(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cfg_start(cfg_start),
        .i_src_w    (src_w),
        .i_src_h    (src_h),
        .i_dst_w    (dst_w),
        .i_dst_h    (dst_h),
        .i_step_x   (step_x),
        .i_step_y   (step_y),
        .o_rd_en    (rd_en),
        .o_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .o_start    (start),
        .o_p1       (p1),
        .o_p2       (p2),
        .o_p3       (p3),
        .o_p4       (p4),
        .o_wx       (wx),
        .o_wy       (wy),
        .o_busy     (busy),
        .o_done     (done)
    );

    logic [7:0] mem [0:511];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[8:0]] : 8'hEE;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  p1, p2, p3, p4;
        logic [15:0] wx, wy;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [11:0] sw, sh, dw, dh;
        logic [15:0] stx, sty;
    } cfg_t;

    typedef struct {
        int          cs;
        int          a1, a2, a3, a4;
        logic [7:0]  p1, p2, p3, p4;
        logic [15:0] wx, wy;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];
    cfg_t cfgs [3];

    ev_t ev_q [$];
    int  addr_q [$];
    int  done_q [$];
    int  first_rd;
    int  max_addr;
    int  start_cyc;
    int  n_tests = 0;
    int  n_fail  = 0;

    always @(negedge clk) begin
        if (rd_en) begin
            addr_q.push_back(int'(rd_addr));
            if (first_rd < 0) first_rd = cyc;
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        end
        if (start) ev_q.push_back('{p1, p2, p3, p4, wx, wy, cyc});
        if (done) done_q.push_back(cyc);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        ev_q.delete();
        addr_q.delete();
        done_q.delete();
        first_rd = -1;
        max_addr = -1;
    endtask

    task automatic setup_mem(input int cs);
        for (int i = 0; i < 512; i++) mem[i] = 8'hEE;
        case (cs)
            0: begin
                mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
            end
            1: begin
                mem[0] = 8'd0; mem[1] = 8'd200;
            end
            2: for (int i = 0; i < 9; i++) mem[i] = 8'(11 * (i + 1));
            default: for (int i = 0; i < 300; i++) mem[i] = 8'(i);
        endcase
    endtask

    // Called and returns at posedge+1
    task automatic start_frame(input cfg_t c);
        clear_mon();
        src_w = c.sw; src_h = c.sh; dst_w = c.dw; dst_h = c.dh;
        step_x = c.stx; step_y = c.sty;
        cfg_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_done_seen"}, 64'(done_q.size() != 0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_outs_zero(input string pfx);
        chk({pfx, "_ctrl"}, 64'({rd_en, start, busy, done}), 64'd0);
        chk({pfx, "_addr"}, 64'(rd_addr), 64'd0);
        chk({pfx, "_pix"},  64'({p1, p2, p3, p4}), 64'd0);
        chk({pfx, "_w"},    64'({wx, wy}), 64'd0);
    endtask

    task automatic compare_case(input int cs);
        int j = 0;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].cs == cs) begin
                if (j < ev_q.size() && 4 * j + 3 < addr_q.size()) begin
                    chk($sformatf("c%0d_px%0d_a1", cs, j), 64'(addr_q[4*j]),   64'(tbl[i].a1));
                    chk($sformatf("c%0d_px%0d_a2", cs, j), 64'(addr_q[4*j+1]), 64'(tbl[i].a2));
                    chk($sformatf("c%0d_px%0d_a3", cs, j), 64'(addr_q[4*j+2]), 64'(tbl[i].a3));
                    chk($sformatf("c%0d_px%0d_a4", cs, j), 64'(addr_q[4*j+3]), 64'(tbl[i].a4));
                    chk($sformatf("c%0d_px%0d_p1", cs, j), 64'(ev_q[j].p1), 64'(tbl[i].p1));
                    chk($sformatf("c%0d_px%0d_p2", cs, j), 64'(ev_q[j].p2), 64'(tbl[i].p2));
                    chk($sformatf("c%0d_px%0d_p3", cs, j), 64'(ev_q[j].p3), 64'(tbl[i].p3));
                    chk($sformatf("c%0d_px%0d_p4", cs, j), 64'(ev_q[j].p4), 64'(tbl[i].p4));
                    chk($sformatf("c%0d_px%0d_wx", cs, j), 64'(ev_q[j].wx), 64'(tbl[i].wx));
                    chk($sformatf("c%0d_px%0d_wy", cs, j), 64'(ev_q[j].wy), 64'(tbl[i].wy));
                    chk($sformatf("c%0d_px%0d_time", cs, j), 64'(ev_q[j].cyc - start_cyc),
                        64'(6 + 6 * j));
                end else begin
                    chk($sformatf("c%0d_px%0d_missing", cs, j), 64'd0, 64'd1);
                end
                j++;
            end
        end
        chk($sformatf("c%0d_npix", cs), 64'(ev_q.size()), 64'(j));
        chk($sformatf("c%0d_nrd", cs), 64'(addr_q.size()), 64'(4 * j));
        chk($sformatf("c%0d_first_rd", cs), 64'(first_rd - start_cyc), 64'd1);
        chk($sformatf("c%0d_ndone", cs), 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0 && ev_q.size() > 0)
            chk($sformatf("c%0d_done_lat", cs), 64'(done_q[0] - ev_q[ev_q.size()-1].cyc), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_t c;
        int   bad;

        cfgs[0] = '{12'd2, 12'd2, 12'd2, 12'd2, 16'h0100, 16'h0100};
        cfgs[1] = '{12'd2, 12'd1, 12'd3, 12'd1, 16'h0080, 16'h0100};
        cfgs[2] = '{12'd3, 12'd3, 12'd2, 12'd2, 16'h0140, 16'h00C0};

        tbl[0]  = '{0, 0, 1, 2, 3, 8'd10, 8'd20, 8'd30, 8'd40, 16'h0000, 16'h0000};
        tbl[1]  = '{0, 1, 1, 3, 3, 8'd20, 8'd20, 8'd40, 8'd40, 16'h0000, 16'h0000};
        tbl[2]  = '{0, 2, 3, 2, 3, 8'd30, 8'd40, 8'd30, 8'd40, 16'h0000, 16'h0000};
        tbl[3]  = '{0, 3, 3, 3, 3, 8'd40, 8'd40, 8'd40, 8'd40, 16'h0000, 16'h0000};
        tbl[4]  = '{1, 0, 1, 0, 1, 8'd0, 8'd200, 8'd0, 8'd200, 16'h0000, 16'h0000};
        tbl[5]  = '{1, 0, 1, 0, 1, 8'd0, 8'd200, 8'd0, 8'd200, 16'h0080, 16'h0000};
        tbl[6]  = '{1, 1, 1, 1, 1, 8'd200, 8'd200, 8'd200, 8'd200, 16'h0000, 16'h0000};
        tbl[7]  = '{2, 0, 1, 3, 4, 8'd11, 8'd22, 8'd44, 8'd55, 16'h0000, 16'h0000};
        tbl[8]  = '{2, 1, 2, 4, 5, 8'd22, 8'd33, 8'd55, 8'd66, 16'h0040, 16'h0000};
        tbl[9]  = '{2, 0, 1, 3, 4, 8'd11, 8'd22, 8'd44, 8'd55, 16'h0000, 16'h00C0};
        tbl[10] = '{2, 1, 2, 4, 5, 8'd22, 8'd33, 8'd55, 8'd66, 16'h0040, 16'h00C0};

        rst_n = 1'b0; cfg_start = 1'b0;
        src_w = '0; src_h = '0; dst_w = '0; dst_h = '0; step_x = '0; step_y = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_outs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int cs = 0; cs < 3; cs++) begin
            setup_mem(cs);
            start_frame(cfgs[cs]);
            chk($sformatf("c%0d_busy_run", cs), 64'(busy), 64'd1);
            wait_done($sformatf("c%0d", cs), 200);
            compare_case(cs);
            chk($sformatf("c%0d_busy_idle", cs), 64'(busy), 64'd0);
        end

        // Empty frames: zero width, then zero height
        for (int z = 0; z < 2; z++) begin
            c = cfgs[0];
            if (z == 0) c.dw = 12'd0; else c.dh = 12'd0;
            start_frame(c);
            wait_done($sformatf("empty%0d", z), 20);
            if (done_q.size() > 0)
                chk($sformatf("empty%0d_done_lat", z), 64'(done_q[0] - start_cyc), 64'd2);
            chk($sformatf("empty%0d_nrd", z), 64'(addr_q.size()), 64'd0);
            chk($sformatf("empty%0d_nstart", z), 64'(ev_q.size()), 64'd0);
            chk($sformatf("empty%0d_ndone", z), 64'(done_q.size()), 64'd1);
        end

        // Start re-pulsed mid-frame with a different config, which then stays applied
        setup_mem(2);
        start_frame(cfgs[2]);
        repeat (9) @(posedge clk);
        #1;
        src_w = 12'd2; src_h = 12'd2; dst_w = 12'd0; dst_h = 12'd5;
        step_x = 16'h0100; step_y = 16'h0100;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        wait_done("repulse", 200);
        compare_case(2);

        // Reset for one cycle right after the second o_start
        setup_mem(0);
        start_frame(cfgs[0]);
        begin
            int n = 0;
            while (ev_q.size() < 2 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("midrst_two_starts", 64'(ev_q.size()), 64'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_outs_zero("midrst");
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_more_start", 64'(ev_q.size()), 64'd2);
        chk("midrst_no_done", 64'(done_q.size()), 64'd0);
        chk("midrst_idle", 64'(busy), 64'd0);

        // Second reset, then a start on the very first cycle after release
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_frame(cfgs[0]);
        wait_done("postrst", 200);
        compare_case(0);

        // Accumulator saturation on a long row
        setup_mem(3);
        c = '{12'd300, 12'd1, 12'd4095, 12'd1, 16'hFFFF, 16'h0100};
        start_frame(c);
        wait_done("sat", 25000);
        chk("sat_npix", 64'(ev_q.size()), 64'd4095);
        chk("sat_max_addr", 64'(max_addr), 64'd299);
        if (ev_q.size() > 1 && addr_q.size() >= 8) begin
            chk("sat_px1_a1", 64'(addr_q[4]), 64'd255);
            chk("sat_px1_a2", 64'(addr_q[5]), 64'd256);
            chk("sat_px1_p2", 64'(ev_q[1].p2), 64'd0);
            chk("sat_px1_wx", 64'(ev_q[1].wx), 64'h00FF);
        end
        bad = 0;
        for (int k = 2; k < ev_q.size() && 4 * k + 3 < addr_q.size(); k++) begin
            for (int m = 0; m < 4; m++) if (addr_q[4*k+m] != 299) bad++;
            if (ev_q[k].wx != 16'h0000 || ev_q[k].p1 != 8'd43) bad++;
        end
        chk("sat_edge_bad", 64'(bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
